gate_tt_checker: RTL
====================

# gate_tt_checker

Self-checking stimulus/response engine for the combinational gate models in this library (OR, AND, etc.). On a start request it sweeps all input vectors of an N-input gate, waits a settle interval per vector, samples the gate output and compares it against a 2^N-bit expected truth table. It reports pass/fail, the error count and the first failing vector. It is the checking end of the gate interface, replacing hand-written `$monitor` eyeballing in benches.

## Interface
- `N_IN`, default 2: number of gate inputs, legal range 1..4; vector count V = 2^N_IN.
- `SETTLE_CYCLES`, default 1: cycles each vector is held before sampling, legal range 1..15.
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `start`, input, 1 bit: begin a sweep; sampled only in IDLE.
- `expect_tt`, input, V bits: bit i is the expected gate output for input vector i; captured when start is accepted.
- `stim`, output, N_IN bits: drives the gate inputs; stim[N_IN-1] is the MSB of the vector index (A for a 2-input gate, B = stim[0]).
- `dut_f`, input, 1 bit: gate output under test.
- `busy`, output, 1 bit: high from the cycle after start is accepted until DONE is exited.
- `done`, output, 1 bit: one-cycle pulse when the sweep completes.
- `pass`, output, 1 bit: 1 if the last sweep had zero mismatches; held until the next start is accepted.
- `err_count`, output, N_IN+1 bits: mismatches in the last or current sweep; saturation is not needed because the maximum is V.
- `fail_vec`, output, N_IN bits: index of the first mismatching vector; 0 if none.
- `fail_seen`, output, 1 bit: at least one mismatch has occurred in the current or last sweep.

## Operation
- The block is an FSM with four states: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- **IDLE:** stim = 0, busy = 0. When start = 1 at an edge:
  - capture expect_tt into tt_q;
  - vec ← 0; err_count, fail_vec, fail_seen and pass ← 0;
  - settle counter ← SETTLE_CYCLES;
  - go to SETTLE.
- **SETTLE:** stim = vec. Decrement the counter each edge. When the counter reaches 1, go to CHECK, so SETTLE lasts exactly SETTLE_CYCLES cycles.
- **CHECK** (one cycle): stim = vec. Compare dut_f with tt_q[vec].
  - On mismatch: err_count increments. If fail_seen = 0, then fail_vec ← vec and fail_seen ← 1.
  - If vec = V−1, go to DONE.
  - Otherwise vec increments, the counter reloads, and the FSM goes to SETTLE.
- **DONE** (one cycle):
  - done = 1, busy = 1, stim holds V−1.
  - pass ← (err_count = 0 after the final compare, including the last vector).
  - Go to IDLE, where stim returns to 0.
- A start pulse while not in IDLE is ignored. start held high in IDLE retriggers a new sweep on the next accepted edge.
- Changes to expect_tt during a sweep have no effect.
- Results (pass, err_count, fail_vec, fail_seen) remain stable in IDLE until the next accepted start clears them.

## Timing
- **Reset values:** stim = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vec = 0, fail_seen = 0, state IDLE.
- **Reset mid-sweep:** all outputs take their reset values immediately, without waiting for a clock edge. There is no done pulse and the partial results are discarded.
- Let edge 0 be the edge that accepts start:
  - vector i is driven from edge i·(S+1) and compared at edge i·(S+1)+S+1, where S = SETTLE_CYCLES;
  - done is high for the cycle following edge V·(S+1);
  - busy falls at edge V·(S+1)+1.
- **Defaults (N_IN = 2, S = 1):**
  - done is high in the cycle after edge 8;
  - the total sweep is 9 cycles from start acceptance back to IDLE.
- **Compare sampling:** dut_f is sampled on the edge that leaves CHECK. The gate path must settle within S cycles of the stim change.

## Test plan
- **OR pass:** OR gate model connected, N_IN = 2, S = 1, expect_tt = 4'b1110, start pulsed → stim sequence 0, 1, 2, 3; done after 8 edges; pass = 1, err_count = 0, fail_seen = 0.
- **Wrong truth table:** OR gate connected, expect_tt = 4'b1000 (AND table) → err_count = 2, fail_vec = 1, fail_seen = 1, pass = 0.
- **Stuck-at-0 output:** dut_f tied 0, expect_tt = 4'b1110 → err_count = 3, fail_vec = 1, pass = 0. Then dut_f tied 1 and the sweep rerun → err_count = 1, fail_vec = 0.
- **Settle timing:** S = 3 → each vector held 4 cycles; done after edge 16; a start pulse at edge 5 is ignored and results are unchanged.
- **Reset mid-sweep:** rst_n pulled low during CHECK of vector 2 → stim, busy and err_count read 0 asynchronously. After release, a new start gives a clean 8-edge sweep with pass = 1.
- **Results hold:** expect_tt toggled mid-sweep and after done → pass, err_count and fail_vec unchanged until the next start.

Source files
------------

// File: rtl/gate_tt_if.sv
// Gate-checker bus: the stimulus/response and result signals between the
// controlling bench (master) and the truth-table checker (slave).
interface gate_tt_if #(
  parameter int unsigned N_IN = 2
) ();
  localparam int unsigned V = 1 << N_IN;

  logic            start;
  logic [V-1:0]    expect_tt;
  logic            dut_f;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] fail_vec;
  logic            fail_seen;

  modport master (
    output start, expect_tt, dut_f,
    input  stim, busy, done, pass, err_count, fail_vec, fail_seen
  );

  modport slave (
    input  start, expect_tt, dut_f,
    output stim, busy, done, pass, err_count, fail_vec, fail_seen
  );
endinterface

// File: rtl/gate_tt_checker.sv
// Truth-table checker for small combinational gates: sweeps every input
// vector, waits SETTLE_CYCLES per vector, samples the gate output and
// compares it with the captured expected table. All outputs are registered.
// The interface instance must be built with the same N_IN as this module.
module gate_tt_checker #(
  parameter int unsigned N_IN          = 2,  // 1..4
  parameter int unsigned SETTLE_CYCLES = 1   // 1..15
) (
  input logic      clk,
  input logic      rst_n,
  gate_tt_if.slave chk_io
);
  localparam int unsigned V = 1 << N_IN;
  localparam logic [N_IN-1:0] LastVec = N_IN'(V - 1);
  localparam logic [3:0] SettleInit = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [V-1:0]    tt_q, tt_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] fail_vec_q, fail_vec_d;
  logic            fail_seen_q, fail_seen_d;
  logic            mismatch;

  assign mismatch = (chk_io.dut_f != tt_q[vec_q]);

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    tt_d        = tt_q;
    stim_d      = stim_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_vec_d  = fail_vec_q;
    fail_seen_d = fail_seen_q;

    unique case (state_q)
      StIdle: begin
        stim_d = '0;
        busy_d = 1'b0;
        if (chk_io.start) begin
          tt_d        = chk_io.expect_tt;
          vec_d       = '0;
          err_d       = '0;
          fail_vec_d  = '0;
          fail_seen_d = 1'b0;
          pass_d      = 1'b0;
          cnt_d       = SettleInit;
          busy_d      = 1'b1;
          state_d     = StSettle;
        end
      end
      StSettle: begin
        // Leaving at count 1 makes SETTLE last exactly SETTLE_CYCLES cycles.
        if (cnt_q <= 4'd1) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fail_seen_q) begin
            fail_vec_d  = vec_q;
            fail_seen_d = 1'b1;
          end
        end
        if (vec_q == LastVec) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 1'b1;
          stim_d  = vec_q + 1'b1;
          cnt_d   = SettleInit;
          state_d = StSettle;
        end
      end
      StDone: begin
        // err_q already includes the last vector's compare here.
        pass_d  = (err_q == '0);
        busy_d  = 1'b0;
        stim_d  = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset drops everything at once, discarding
  // any partial sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      vec_q       <= '0;
      cnt_q       <= '0;
      tt_q        <= '0;
      stim_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_vec_q  <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      tt_q        <= tt_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_vec_q  <= fail_vec_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  assign chk_io.stim      = stim_q;
  assign chk_io.busy      = busy_q;
  assign chk_io.done      = done_q;
  assign chk_io.pass      = pass_q;
  assign chk_io.err_count = err_q;
  assign chk_io.fail_vec  = fail_vec_q;
  assign chk_io.fail_seen = fail_seen_q;
endmodule
